// File: rtl/dcim_mac_sched.sv
// rtl/dcim_mac_sched.sv - bit-serial activation/weight sequencer and shift-accumulator for one DCIM MAC column
module dcim_mac_sched #(
   parameter int INPUT_WIDTH = 144,
   parameter int PSUM_WIDTH  = 12,
   parameter int IN_BITS     = 8,
   parameter int W_BITS      = 8,
   parameter int ACC_WIDTH   = 32,
   localparam int IB_W = (IN_BITS > 1) ? $clog2(IN_BITS) : 1,
   localparam int WS_W = (W_BITS > 1) ? $clog2(W_BITS) : 1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [INPUT_WIDTH*IN_BITS-1:0] in_act,
   input  logic                           abort,
   output logic [INPUT_WIDTH-1:0]         rwlb,
   output logic [WS_W-1:0]                w_sel,
   input  logic [PSUM_WIDTH-1:0]          psum,
   output logic                           busy,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [ACC_WIDTH-1:0]           out_data
);

   // shift amount must hold (W_BITS-1)+(IN_BITS-1)
   localparam int SH_W = IB_W + WS_W;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [ACC_WIDTH-1:0]   acc_q, acc_d;
   logic [ACC_WIDTH-1:0]   out_data_q, out_data_d;
   logic [IB_W-1:0]        ib_q, ib_d;
   logic [WS_W-1:0]        ws_q, ws_d;
   logic [IN_BITS-1:0]     act_q [INPUT_WIDTH];
   logic                   load_act;

   logic [SH_W-1:0]        shamt;
   logic [ACC_WIDTH-1:0]   psum_ext;
   logic [ACC_WIDTH-1:0]   addend;

   // weighted partial sum for the current (weight slice, input bit) pair
   always_comb begin
      shamt    = SH_W'(ws_q) + SH_W'(ib_q);
      psum_ext = ACC_WIDTH'(psum);
      addend   = psum_ext << shamt;
   end

   // next-state, counter advance and column drive
   always_comb begin
      state_d    = state_q;
      acc_d      = acc_q;
      out_data_d = out_data_q;
      ib_d       = ib_q;
      ws_d       = ws_q;
      load_act   = 1'b0;
      in_ready   = (state_q == S_IDLE);
      busy       = (state_q == S_RUN);
      out_valid  = (state_q == S_DONE);
      rwlb       = '0;
      w_sel      = '0;

      if (state_q == S_RUN) begin
         w_sel = ws_q;
         for (int i = 0; i < INPUT_WIDTH; i++) begin
            rwlb[i] = act_q[i][ib_q];
         end
      end

      if (abort) begin
         state_d = S_IDLE;
         acc_d   = '0;
         ib_d    = '0;
         ws_d    = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  load_act = 1'b1;
                  acc_d    = '0;
                  ib_d     = '0;
                  ws_d     = '0;
                  state_d  = S_RUN;
               end
            end
            S_RUN: begin
               acc_d = acc_q + addend;
               // input bit is the inner loop, weight slice the outer loop
               if (ib_q == IB_W'(IN_BITS - 1)) begin
                  ib_d = '0;
                  if (ws_q == WS_W'(W_BITS - 1)) begin
                     ws_d       = '0;
                     out_data_d = acc_d;
                     state_d    = S_DONE;
                  end else begin
                     ws_d = ws_q + 1'b1;
                  end
               end else begin
                  ib_d = ib_q + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_d = S_IDLE;
               end
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // accumulator, counters and held result
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         acc_q      <= '0;
         out_data_q <= '0;
         ib_q       <= '0;
         ws_q       <= '0;
      end else begin
         acc_q      <= acc_d;
         out_data_q <= out_data_d;
         ib_q       <= ib_d;
         ws_q       <= ws_d;
      end
   end

   // activation latch; only read while running, so it needs no reset
   always_ff @(posedge clk) begin
      if (load_act) begin
         for (int i = 0; i < INPUT_WIDTH; i++) begin
            act_q[i] <= in_act[i*IN_BITS +: IN_BITS];
         end
      end
   end

   assign out_data = out_data_q;

endmodule

// File: tb/tb_dcim_mac_sched.sv
// tb/tb_dcim_mac_sched.sv - randomized self-checking bench for dcim_mac_sched
module tb_dcim_mac_sched;

   localparam int IW = 144;
   localparam int IB = 8;
   localparam int WB = 8;
   localparam int PW = 12;
   localparam int AW = 32;
   localparam int N  = IB * WB;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [IW*IB-1:0]  in_act;
   logic              abort;
   logic [IW-1:0]     rwlb;
   logic [2:0]        w_sel;
   logic [PW-1:0]     psum;
   logic              busy;
   logic              out_valid;
   logic              out_ready;
   logic [AW-1:0]     out_data;

   logic [7:0]        w [IW];

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 1'b0;

   // model: -1 idle, 0..N-1 running step k, N done
   int               m_k = -1;
   logic [IW*IB-1:0] m_act;
   logic [AW-1:0]    m_result;

   always #5 clk = ~clk;

   dcim_mac_sched dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_act    (in_act),
      .abort     (abort),
      .rwlb      (rwlb),
      .w_sel     (w_sel),
      .psum      (psum),
      .busy      (busy),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
   );

   // CIM bank plus local MAC: popcount of (rwlb AND selected weight bit)
   always_comb begin
      int s;
      s = 0;
      for (int i = 0; i < IW; i++) begin
         if (rwlb[i] && w[i][w_sel]) s = s + 1;
      end
      psum = s[PW-1:0];
   end

   function automatic logic [AW-1:0] dot(input logic [IW*IB-1:0] a);
      longint acc;
      acc = 0;
      for (int i = 0; i < IW; i++) begin
         acc = acc + longint'(a[i*IB +: IB]) * longint'(w[i]);
      end
      return acc[AW-1:0];
   endfunction

   function automatic logic [IW-1:0] plane(input logic [IW*IB-1:0] a, input int b);
      logic [IW-1:0] p;
      for (int i = 0; i < IW; i++) p[i] = a[i*IB + b];
      return p;
   endfunction

   task automatic check(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // reference model, advanced at each active edge from sampled inputs
   always @(posedge clk) begin
      if (!rst_n || abort) begin
         m_k = -1;
      end else if (m_k == -1) begin
         if (in_valid) begin
            m_act    = in_act;
            m_result = dot(in_act);
            m_k      = 0;
         end
      end else if (m_k < N) begin
         m_k = m_k + 1;
      end else if (out_ready) begin
         m_k = -1;
      end
   end

   // compare DUT against the model every cycle, away from the active edge
   always @(negedge clk) begin
      if (chk_en) begin
         check("in_ready", in_ready, (m_k == -1));
         check("busy", busy, (m_k >= 0 && m_k < N));
         check("out_valid", out_valid, (m_k == N));
         if (m_k >= 0 && m_k < N) begin
            check("w_sel", w_sel, m_k / IB);
            check("rwlb", rwlb, plane(m_act, m_k % IB));
         end else begin
            check("w_sel_idle", w_sel, 0);
            check("rwlb_idle", rwlb, 0);
         end
         if (m_k == N) check("out_data", out_data, m_result);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [IW*IB-1:0] rand_act();
      logic [IW*IB-1:0] v;
      for (int i = 0; i < IW; i++) v[i*IB +: IB] = 8'($urandom);
      return v;
   endfunction

   // send one vector, hold out_ready low for 'hold' DONE cycles, return latency and result
   task automatic run_vec(input logic [IW*IB-1:0] a, input int hold,
                          output int lat, output logic [AW-1:0] res);
      in_act    = a;
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      tick();
      in_valid = 1'b0;
      in_act   = rand_act();
      lat = 1;
      while (!out_valid && lat < 200) begin
         tick();
         lat++;
      end
      if (!out_valid) check("out_valid_timeout", 0, 1);
      res = out_data;
      for (int h = 0; h < hold; h++) begin
         if (h == hold / 2) begin
            in_valid = 1'b1;
            in_act   = rand_act();
         end
         tick();
         in_valid = 1'b0;
      end
      out_ready = 1'b1;
      tick();
   endtask

   initial begin
      int lat;
      logic [AW-1:0] res;
      logic [IW*IB-1:0] ones, fulls;
      for (int i = 0; i < IW; i++) begin
         ones[i*IB +: IB]  = 8'h01;
         fulls[i*IB +: IB] = 8'hFF;
      end

      rst_n = 1'b0; in_valid = 1'b0; in_act = '0; abort = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < IW; i++) w[i] = 8'd1;
      repeat (3) tick();
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_rwlb", rwlb, 0);
      check("rst_busy", busy, 0);
      check("rst_w_sel", w_sel, 0);
      rst_n = 1'b1;
      tick();
      chk_en = 1'b1;

      run_vec(ones, 0, lat, res);
      check("ones_result", res, 144);
      check("ones_latency", lat, 65);
      check("ones_in_ready_after", in_ready, 1);

      for (int i = 0; i < IW; i++) w[i] = 8'hFF;
      run_vec(fulls, 0, lat, res);
      check("max_result", res, 9363600);

      for (int i = 0; i < IW; i++) w[i] = 8'($urandom);
      run_vec(rand_act(), 10, lat, res);
      check("bp_in_ready_idle", in_ready, 1);

      for (int i = 0; i < IW; i++) w[i] = 8'd1;
      in_act = ones; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (20) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", busy, 0);
      check("abort_in_ready", in_ready, 1);
      run_vec(ones, 0, lat, res);
      check("post_abort_result", res, 144);

      abort = 1'b1; in_valid = 1'b1; in_act = fulls;
      tick();
      abort = 1'b0; in_valid = 1'b0;
      check("abort_idle_busy", busy, 0);

      in_act = ones; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("midrun_reset_busy", busy, 0);

      for (int v = 0; v < 200; v++) begin
         for (int i = 0; i < IW; i++) w[i] = 8'($urandom);
         run_vec(rand_act(), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0, lat, res);
         if (v % 50 == 0) check("rand_latency", lat, 65);
      end

      tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #3000000;
      n_err++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "watchdog");
   end

endmodule
